dcache_axi_bridge: RTL

- Single-outstanding bridge directly downstream of the data cache.
- Converts the cache's memory-side strobe/ready request (`m_*`) into AXI4 single-beat read and write transactions toward the SoC interconnect.
- Read misses become one AR/R transaction; write-through stores become one AW/W/B transaction.
- Burst sideband fields (len=0, size=2, burst=INCR, id=0, wlast=1, lock/cache/prot=0) are tied off in the SoC wrapper, not in this block.

---
 rtl/dcache_axi_bridge.sv | 133 +++++++++++++
 1 files changed

// File: rtl/dcache_axi_bridge.sv
// Single-outstanding bridge from the data cache strobe/ready port
// to AXI4 single-beat reads and write-through stores.
module dcache_axi_bridge #(
  parameter int A_WIDTH = 32
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [A_WIDTH-1:0] m_a,
  input  logic [31:0]        m_din,
  input  logic               m_strobe,
  input  logic               m_rw,
  output logic [31:0]        m_dout,
  output logic               m_ready,
  output logic               bus_err,
  output logic [A_WIDTH-1:0] araddr,
  output logic               arvalid,
  input  logic               arready,
  input  logic [31:0]        rdata,
  input  logic [1:0]         rresp,
  input  logic               rvalid,
  output logic               rready,
  output logic [A_WIDTH-1:0] awaddr,
  output logic               awvalid,
  input  logic               awready,
  output logic [31:0]        wdata,
  output logic [3:0]         wstrb,
  output logic               wvalid,
  input  logic               wready,
  input  logic [1:0]         bresp,
  input  logic               bvalid,
  output logic               bready
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [A_WIDTH-1:0] addr_q;
  logic [31:0]        wdata_q;
  logic               aw_done;
  logic               w_done;
  logic               aw_hs;
  logic               w_hs;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    arvalid = 1'b0;
    rready  = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    m_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (m_strobe)
          state_n = m_rw ? WR_REQ : RD_ADDR;
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_n = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (rvalid) state_n = DONE;
      end
      WR_REQ: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        // either channel may finish first, or both together
        if ((aw_done || awready) &&
            (w_done || wready))
          state_n = WR_RESP;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) state_n = DONE;
      end
      DONE: begin
        m_ready = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      m_dout  <= '0;
      bus_err <= 1'b0;
    end else begin
      if (state == IDLE && m_strobe) begin
        addr_q  <= m_a;
        wdata_q <= m_din;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (state == RD_DATA && rvalid) begin
        m_dout <= rdata;
        if (rresp != 2'b00) bus_err <= 1'b1;
      end
      if (state == WR_RESP && bvalid &&
          bresp != 2'b00)
        bus_err <= 1'b1;
    end
  end

  assign araddr = addr_q;
  assign awaddr = addr_q;
  assign wdata  = wdata_q;
  assign wstrb  = 4'hF;

endmodule
